// File: rtl/aes_dec_pkg.sv
// aes_dec_pkg: shared types, constants and GF(2^8) helpers for the AES decryption
// round core (inv_ark_mix_round) and its column mixer (inv_mix_col).
//   state_e            FSM state encoding of the round core
//   AES_POLY           low byte of the AES reduction polynomial x^8+x^4+x^3+x+1
//   INV_MIX_C0..C3     InvMixColumns row coefficients 0e/0b/0d/09
//   xtime, gmul        multiply by x, multiply by an arbitrary byte
//   get_col, set_col   32-bit column access; column 0 lives in bits [127:96]
package aes_dec_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MIX  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic [7:0] AES_POLY = 8'h1B;

   localparam logic [7:0] INV_MIX_C0 = 8'h0e;
   localparam logic [7:0] INV_MIX_C1 = 8'h0b;
   localparam logic [7:0] INV_MIX_C2 = 8'h0d;
   localparam logic [7:0] INV_MIX_C3 = 8'h09;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
   endfunction

   // Shift-and-add multiply; with a constant c the unused partial products fold away.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] c);
      logic [7:0] acc;
      logic [7:0] p;
      acc = '0;
      p   = a;
      for (int i = 0; i < 8; i++) begin
         if (c[i]) acc = acc ^ p;
         p = xtime(p);
      end
      return acc;
   endfunction

   function automatic logic [31:0] get_col(input logic [127:0] st, input logic [1:0] idx);
      return st[32 * (3 - int'(idx)) +: 32];
   endfunction

   function automatic logic [127:0] set_col(input logic [127:0] st, input logic [1:0] idx,
                                            input logic [31:0] col);
      logic [127:0] r;
      r = st;
      r[32 * (3 - int'(idx)) +: 32] = col;
      return r;
   endfunction

endpackage

// File: rtl/inv_mix_col.sv
// inv_mix_col: combinational InvMixColumns on one 32-bit column.
//   col_i  input column, [31:24] = row 0 ... [7:0] = row 3
//   col_o  mixed column, same byte order
//   out row r = 0e*a[r] ^ 0b*a[r+1] ^ 0d*a[r+2] ^ 09*a[r+3] (indices mod 4)
module inv_mix_col
   import aes_dec_pkg::*;
(
   input  logic [31:0] col_i,
   output logic [31:0] col_o
);

   logic [7:0] a [4];

   always_comb begin
      a     = '{default: '0};
      col_o = '0;
      for (int r = 0; r < 4; r++) begin
         a[r] = col_i[8 * (3 - r) +: 8];
      end
      for (int r = 0; r < 4; r++) begin
         col_o[8 * (3 - r) +: 8] = gmul(a[r],           INV_MIX_C0) ^
                                   gmul(a[(r + 1) % 4], INV_MIX_C1) ^
                                   gmul(a[(r + 2) % 4], INV_MIX_C2) ^
                                   gmul(a[(r + 3) % 4], INV_MIX_C3);
      end
   end

endmodule

// File: rtl/inv_ark_mix_round.sv
// inv_ark_mix_round: column-serial AES decryption round core.
// AddRoundKey is applied on accept; InvMixColumns then runs over 4/COLS_PER_CYCLE cycles
// through COLS_PER_CYCLE shared column mixers, writing each column back in place.
// A final-round state (in_last) skips the mix and is offered the cycle after accept.
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake; in_ready only in IDLE
//   in_state, in_key      128-bit state and round key, column 0 in [127:96]
//   in_last               final round: AddRoundKey only
//   out_valid/out_ready   output handshake; out_state held until taken
//   out_state             round result, driven straight from the work register
//   busy                  FSM not idle
// COLS_PER_CYCLE must be 1, 2 or 4.
module inv_ark_mix_round
   import aes_dec_pkg::*;
#(
   parameter int unsigned COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   input  logic [127:0] in_key,
   input  logic         in_last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         busy
);

   localparam logic [2:0] ColStep = 3'(COLS_PER_CYCLE);

   state_e       state_q, state_d;
   logic [127:0] work_q,  work_d;
   logic [1:0]   col_cnt_q, col_cnt_d;
   logic         last_q,  last_d;

   logic [31:0]  mix_in  [COLS_PER_CYCLE];
   logic [31:0]  mix_out [COLS_PER_CYCLE];

   // col_cnt is always a multiple of COLS_PER_CYCLE, so the group end never exceeds 4;
   // bit 2 set means column 3 is written this cycle.
   logic [2:0]   col_end;
   logic         mix_last;

   assign col_end  = {1'b0, col_cnt_q} + ColStep;
   assign mix_last = col_end[2];

   for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_mix
      assign mix_in[g] = get_col(work_q, col_cnt_q + 2'(g));

      inv_mix_col u_inv_mix_col (
         .col_i (mix_in[g]),
         .col_o (mix_out[g])
      );
   end

   always_comb begin
      state_d   = state_q;
      work_d    = work_q;
      col_cnt_d = col_cnt_q;
      last_d    = last_q;

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               work_d    = in_state ^ in_key;
               last_d    = in_last;
               col_cnt_d = '0;
               state_d   = in_last ? DONE : MIX;
            end
         end
         MIX: begin
            // A final-round state never enters MIX; the guard keeps it unmixed regardless.
            if (!last_q) begin
               for (int g = 0; g < int'(COLS_PER_CYCLE); g++) begin
                  work_d = set_col(work_d, col_cnt_q + 2'(g), mix_out[g]);
               end
            end
            col_cnt_d = col_end[1:0];
            if (mix_last) state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         work_q    <= '0;
         col_cnt_q <= '0;
         last_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         work_q    <= work_d;
         col_cnt_q <= col_cnt_d;
         last_q    <= last_d;
      end
   end

   // Handshake outputs come from the state register only.
   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_state = work_q;

endmodule
